// File: rtl/chorus_pkg.sv
// Shared types and constants for the multi-voice chorus datapath.
package chorus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        MIX   = 2'd3
    } state_t;

    localparam int MIX_SHIFT = 4;
    localparam int WET_FULL  = 16;

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port delay-line memory: synchronous write, registered read (one cycle).
module delay_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/multi_voice_chorus.sv
// Multi-voice chorus: writes each dry sample into a delay line, sums NUM_VOICES taps,
// and blends the averaged wet signal with the dry sample.
module multi_voice_chorus
    import chorus_pkg::*;
#(
    parameter int PKT_WIDTH  = 16,
    parameter int BUF_DEPTH  = 4096,
    parameter int NUM_VOICES = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [PKT_WIDTH-1:0]                   pkt_i,
    input  logic                                   pktChanged_i,
    input  logic [NUM_VOICES*$clog2(BUF_DEPTH)-1:0] delay_i,
    input  logic [3:0]                             wetLevel_i,
    input  logic                                   bypass_i,
    output logic [PKT_WIDTH-1:0]                   pktMixed_o,
    output logic                                   pktMixChanged_o,
    output logic                                   busy_o,
    output logic                                   overrun_o
);

    localparam int DELAY_WIDTH = $clog2(BUF_DEPTH);
    localparam int VOICE_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int AVG_SHIFT   = $clog2(NUM_VOICES);
    localparam int ACC_W       = PKT_WIDTH + 3;
    localparam int MIX_W       = PKT_WIDTH + 6;
    localparam logic [DELAY_WIDTH:0] FILL_MAX = (DELAY_WIDTH+1)'(BUF_DEPTH);

    state_t state;
    state_t stateNext;

    logic                                   accept;
    logic [DELAY_WIDTH-1:0]                 wrPtr;
    logic [DELAY_WIDTH-1:0]                 basePtr;
    logic [DELAY_WIDTH:0]                   fillCount;
    logic [VOICE_W-1:0]                     voiceIdx;
    logic                                   lastVoice;

    logic signed [PKT_WIDTH-1:0]            dry;
    logic [NUM_VOICES*DELAY_WIDTH-1:0]      delays;
    logic [3:0]                             wetLevel;
    logic                                   bypass;

    logic [DELAY_WIDTH-1:0]                 curDelay;
    logic [DELAY_WIDTH-1:0]                 rdAddr_p0;
    logic                                   tapVld_p0;
    logic [PKT_WIDTH-1:0]                   rdData_p1;
    logic signed [PKT_WIDTH-1:0]            tap_p1;
    logic                                   tapVld_p1;
    logic signed [ACC_W-1:0]                acc;

    function automatic logic signed [PKT_WIDTH-1:0] mixSample(
        input logic signed [PKT_WIDTH-1:0] drySample,
        input logic signed [ACC_W-1:0]     accum,
        input logic [3:0]                  wet
    );
        logic signed [ACC_W-1:0] wetAvg;
        logic signed [5:0]       dryGain;
        logic signed [5:0]       wetGain;
        logic signed [MIX_W-1:0] sum;
        logic signed [MIX_W-1:0] scaled;
        wetAvg  = accum >>> AVG_SHIFT;
        dryGain = 6'(WET_FULL) - 6'(wet);
        wetGain = 6'(wet);
        sum     = (MIX_W'(drySample) * MIX_W'(dryGain)) + (MIX_W'(wetAvg) * MIX_W'(wetGain));
        scaled  = sum >>> MIX_SHIFT;
        return scaled[PKT_WIDTH-1:0];
    endfunction

    assign accept    = (state == IDLE) && pktChanged_i;
    assign busy_o    = (state != IDLE);
    assign lastVoice = (voiceIdx == VOICE_W'(NUM_VOICES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (pktChanged_i) stateNext = READ;
            READ:    if (lastVoice) stateNext = DRAIN;
            DRAIN:   stateNext = MIX;
            MIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Sample capture: everything the in-flight sample needs is frozen here
    always_ff @(posedge clk_i) begin
        if (accept) begin
            dry      <= pkt_i;
            delays   <= delay_i;
            wetLevel <= wetLevel_i;
            bypass   <= bypass_i;
            basePtr  <= wrPtr;
        end
    end

    // Stage p0: tap address issue; taps older than the written history are masked
    always_comb begin
        curDelay  = delays[int'(voiceIdx)*DELAY_WIDTH +: DELAY_WIDTH];
        rdAddr_p0 = basePtr - curDelay;
        tapVld_p0 = (state == READ) && ({1'b0, curDelay} < fillCount);
    end

    delay_ram #(
        .WIDTH(PKT_WIDTH),
        .DEPTH(BUF_DEPTH)
    ) uRam (
        .clk    (clk_i),
        .wrEn   (accept && !reset_i),
        .wrAddr (wrPtr),
        .wrData (pkt_i),
        .rdAddr (rdAddr_p0),
        .rdData (rdData_p1)
    );

    // Stage p1: RAM data returns and accumulates; MIX blends into the output register
    assign tap_p1 = rdData_p1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr           <= '0;
            fillCount       <= '0;
            voiceIdx        <= '0;
            tapVld_p1       <= 1'b0;
            acc             <= '0;
            pktMixed_o      <= '0;
            pktMixChanged_o <= 1'b0;
            overrun_o       <= 1'b0;
        end else begin
            pktMixChanged_o <= 1'b0;
            tapVld_p1       <= tapVld_p0;
            if (pktChanged_i && (state != IDLE)) begin
                overrun_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pktChanged_i) begin
                        wrPtr    <= wrPtr + 1'b1;
                        voiceIdx <= '0;
                        acc      <= '0;
                        if (fillCount != FILL_MAX) begin
                            fillCount <= fillCount + 1'b1;
                        end
                    end
                end
                READ: begin
                    voiceIdx <= lastVoice ? '0 : voiceIdx + 1'b1;
                    if (tapVld_p1) begin
                        acc <= acc + ACC_W'(tap_p1);
                    end
                end
                DRAIN: begin
                    if (tapVld_p1) begin
                        acc <= acc + ACC_W'(tap_p1);
                    end
                end
                MIX: begin
                    pktMixed_o      <= bypass ? dry : mixSample(dry, acc, wetLevel);
                    pktMixChanged_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_voice_chorus.sv
// Self-checking bench for multi_voice_chorus (BUF_DEPTH=16, NUM_VOICES=2, latency 5).
module tb_multi_voice_chorus;

    localparam int PW = 16;
    localparam int BD = 16;
    localparam int NV = 2;
    localparam int DW = 4;

    logic           clk = 1'b0;
    logic           reset_i = 1'b0;
    logic [PW-1:0]  pkt_i = '0;
    logic           pktChanged_i = 1'b0;
    logic [NV*DW-1:0] delay_i = '0;
    logic [3:0]     wetLevel_i = '0;
    logic           bypass_i = 1'b0;
    logic [PW-1:0]  pktMixed_o;
    logic           pktMixChanged_o;
    logic           busy_o;
    logic           overrun_o;

    int checks = 0;
    int errors = 0;
    int hist[$];

    always #5 clk = ~clk;

    multi_voice_chorus #(
        .PKT_WIDTH(PW),
        .BUF_DEPTH(BD),
        .NUM_VOICES(NV)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .pkt_i           (pkt_i),
        .pktChanged_i    (pktChanged_i),
        .delay_i         (delay_i),
        .wetLevel_i      (wetLevel_i),
        .bypass_i        (bypass_i),
        .pktMixed_o      (pktMixed_o),
        .pktMixChanged_o (pktMixChanged_o),
        .busy_o          (busy_o),
        .overrun_o       (overrun_o)
    );

    // Reference: taps come from the list of samples written since reset.
    function automatic logic [15:0] modelMix(input logic [15:0] dry, input int d0, input int d1,
                                             input int w, input bit byp);
        int ds[2];
        int sum;
        int avg;
        int mix;
        int n;
        if (byp) return dry;
        ds[0] = d0;
        ds[1] = d1;
        sum = 0;
        n = hist.size();
        foreach (ds[i]) begin
            if (ds[i] < n) sum += hist[n - 1 - ds[i]];
        end
        avg = sum >>> 1;
        mix = (int'($signed(dry)) * (16 - w) + avg * w) >>> 4;
        return mix[15:0];
    endfunction

    task automatic doReset();
        @(negedge clk);
        reset_i = 1'b1;
        pktChanged_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        hist.delete();
    endtask

    task automatic drive(input logic [15:0] pkt, input int d0, input int d1, input int w,
                         input bit byp, input int dupAt, input int rstAt,
                         output int strobeAt, output int strobeCnt,
                         output logic [15:0] val, output int busyMask);
        strobeAt = -1;
        strobeCnt = 0;
        val = '0;
        busyMask = 0;
        @(negedge clk);
        pkt_i = pkt;
        delay_i = {4'(d1), 4'(d0)};
        wetLevel_i = 4'(w);
        bypass_i = byp;
        pktChanged_i = 1'b1;
        @(negedge clk);
        pktChanged_i = 1'b0;
        pkt_i = 16'($urandom);
        delay_i = 8'($urandom);
        wetLevel_i = 4'($urandom);
        bypass_i = 1'($urandom);
        for (int k = 1; k <= 8; k++) begin
            if (busy_o) busyMask |= (1 << k);
            if (pktMixChanged_o) begin
                strobeCnt++;
                if (strobeAt < 0) begin
                    strobeAt = k;
                    val = pktMixed_o;
                end
            end
            pktChanged_i = (k == dupAt);
            if (k == dupAt) pkt_i = 16'h7777;
            reset_i = (k == rstAt);
            @(negedge clk);
        end
        pktChanged_i = 1'b0;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (pktMixed_o !== 16'h0) begin errors++; $display("FAIL reset_mixed: got %h expected 0000", pktMixed_o); end
        checks++; if (pktMixChanged_o !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", pktMixChanged_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
    endtask

    task automatic test_basic();
        int sa, sc, bm;
        logic [15:0] v;
        doReset();
        hist.push_back(int'($signed(16'h1000)));
        drive(16'h1000, 0, 0, 8, 1'b0, 0, 0, sa, sc, v, bm);
        checks++; if (v !== 16'h1000) begin errors++; $display("FAIL basic_value: got %h expected 1000", v); end
        checks++; if (sa !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", sa); end
        checks++; if (sc !== 1) begin errors++; $display("FAIL basic_strobe_count: got %0d expected 1", sc); end
        checks++; if (bm !== 30) begin errors++; $display("FAIL basic_busy_window: got %b expected 11110", bm); end
        checks++; if (pktMixed_o !== 16'h1000) begin errors++; $display("FAIL basic_hold: got %h expected 1000", pktMixed_o); end
    endtask

    task automatic test_first();
        int sa, sc, bm;
        logic [15:0] v;
        doReset();
        hist.push_back(int'($signed(16'h0800)));
        drive(16'h0800, 1, 1, 15, 1'b0, 0, 0, sa, sc, v, bm);
        checks++; if (v !== 16'h0080) begin errors++; $display("FAIL first_masked: got %h expected 0080", v); end
        checks++; if (v !== modelMix(16'h0800, 1, 1, 15, 1'b0)) begin errors++; $display("FAIL first_model: got %h expected %h", v, modelMix(16'h0800, 1, 1, 15, 1'b0)); end
    endtask

    task automatic test_wrap();
        int sa, sc, bm, d0, d1, w;
        logic [15:0] v, e;
        doReset();
        for (int i = 0; i < 19; i++) begin
            d0 = $urandom_range(0, 15);
            d1 = $urandom_range(0, 15);
            w = $urandom_range(0, 15);
            hist.push_back(i);
            e = modelMix(16'(i), d0, d1, w, 1'b0);
            drive(16'(i), d0, d1, w, 1'b0, 0, 0, sa, sc, v, bm);
            checks++; if (v !== e || sa !== 5) begin errors++; $display("FAIL wrap_fill[%0d]: got %h@%0d expected %h@5", i, v, sa, e); end
        end
        hist.push_back(19);
        drive(16'd19, 3, 5, 15, 1'b0, 0, 0, sa, sc, v, bm);
        checks++; if (v !== 16'h000F) begin errors++; $display("FAIL wrap_taps: got %h expected 000f", v); end
    endtask

    task automatic test_sign_bypass();
        int sa, sc, bm;
        logic [15:0] v;
        hist.push_back(int'($signed(16'hC000)));
        drive(16'hC000, 0, 0, 0, 1'b0, 0, 0, sa, sc, v, bm);
        checks++; if (v !== 16'hC000) begin errors++; $display("FAIL sign_dry: got %h expected c000", v); end
        hist.push_back(int'($signed(16'hC000)));
        drive(16'hC000, 0, 0, 15, 1'b1, 0, 0, sa, sc, v, bm);
        checks++; if (v !== 16'hC000 || sa !== 5) begin errors++; $display("FAIL bypass: got %h@%0d expected c000@5", v, sa); end
        hist.push_back(int'($signed(16'h8000)));
        drive(16'h8000, 1, 0, 15, 1'b0, 0, 0, sa, sc, v, bm);
        checks++; if (v !== modelMix(16'h8000, 1, 0, 15, 1'b0)) begin errors++; $display("FAIL sign_neg_mix: got %h expected %h", v, modelMix(16'h8000, 1, 0, 15, 1'b0)); end
    endtask

    task automatic test_overrun();
        int sa, sc, bm;
        logic [15:0] v;
        doReset();
        hist.push_back(int'($signed(16'h0100)));
        drive(16'h0100, 0, 0, 0, 1'b0, 2, 0, sa, sc, v, bm);
        checks++; if (sc !== 1 || sa !== 5) begin errors++; $display("FAIL overrun_strobes: got %0d@%0d expected 1@5", sc, sa); end
        checks++; if (v !== 16'h0100) begin errors++; $display("FAIL overrun_value: got %h expected 0100", v); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", overrun_o); end
        hist.push_back(int'($signed(16'h0200)));
        drive(16'h0200, 1, 0, 15, 1'b0, 0, 0, sa, sc, v, bm);
        checks++; if (v !== 16'h0188) begin errors++; $display("FAIL overrun_wrptr: got %h expected 0188", v); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun_o); end
        doReset();
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun_o); end
    endtask

    task automatic test_reset_midflight();
        int sa, sc, bm;
        logic [15:0] v;
        doReset();
        hist.push_back(int'($signed(16'h1234)));
        drive(16'h1234, 0, 0, 0, 1'b0, 0, 0, sa, sc, v, bm);
        checks++; if (v !== 16'h1234) begin errors++; $display("FAIL midrst_pre: got %h expected 1234", v); end
        drive(16'h4000, 0, 0, 8, 1'b0, 0, 2, sa, sc, v, bm);
        hist.delete();
        checks++; if (sc !== 0) begin errors++; $display("FAIL midrst_no_strobe: got %0d expected 0", sc); end
        checks++; if (pktMixed_o !== 16'h0 || busy_o !== 1'b0 || overrun_o !== 1'b0 || pktMixChanged_o !== 1'b0)
            begin errors++; $display("FAIL midrst_outputs: got %h/%b/%b/%b expected 0000/0/0/0", pktMixed_o, busy_o, overrun_o, pktMixChanged_o); end
        hist.push_back(int'($signed(16'h0800)));
        drive(16'h0800, 1, 1, 15, 1'b0, 0, 0, sa, sc, v, bm);
        checks++; if (v !== 16'h0080) begin errors++; $display("FAIL midrst_first: got %h expected 0080", v); end
    endtask

    task automatic test_random();
        int sa, sc, bm, d0, d1, w;
        bit byp;
        logic [15:0] p, v, e;
        for (int i = 0; i < 40; i++) begin
            p = 16'($urandom);
            d0 = $urandom_range(0, 15);
            d1 = $urandom_range(0, 15);
            w = $urandom_range(0, 15);
            byp = ($urandom_range(0, 3) == 0);
            hist.push_back(int'($signed(p)));
            e = modelMix(p, d0, d1, w, byp);
            drive(p, d0, d1, w, byp, 0, 0, sa, sc, v, bm);
            checks++; if (v !== e || sa !== 5 || sc !== 1)
                begin errors++; $display("FAIL random[%0d]: got %h@%0d x%0d expected %h@5 x1", i, v, sa, sc, e); end
        end
    endtask

    initial begin
        test_reset();
        test_first();
        test_basic();
        test_wrap();
        test_sign_bypass();
        test_overrun();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_voice_chorus.md
MULTI_VOICE_CHORUS -- requirements
Module: multi_voice_chorus

Interface
REQ-001 SHALL have parameter PKT_WIDTH, default 16: signed two's-complement audio sample width.
REQ-002 SHALL have parameter BUF_DEPTH, default 4096: delay-line depth in samples; power of two, >= 4.
REQ-003 SHALL have parameter NUM_VOICES, default 4: delayed taps summed into the wet signal; one of 1, 2, 4, 8.
REQ-004 SHALL derive localparam DELAY_WIDTH = clog2(BUF_DEPTH).
REQ-005 clk_i  input  1  DSP clock; one clock domain; all logic on its rising edge.
REQ-006 reset_i  input  1  synchronous, active-high reset.
REQ-007 pkt_i  input  PKT_WIDTH  dry sample; valid while pktChanged_i is high.
REQ-008 pktChanged_i  input  1  single-cycle new-sample strobe.
REQ-009 delay_i  input  NUM_VOICES*DELAY_WIDTH  per-voice delay in samples; voice v occupies bits [v*DELAY_WIDTH +: DELAY_WIDTH].
REQ-010 wetLevel_i  input  4  wet weight w, 0..15, out of 16.
REQ-011 bypass_i  input  1  output dry sample only.
REQ-012 pktMixed_o  output  PKT_WIDTH  mixed sample; holds between strobes.
REQ-013 pktMixChanged_o  output  1  single-cycle strobe, new pktMixed_o.
REQ-014 busy_o  output  1  high whenever FSM is not IDLE.
REQ-015 overrun_o  output  1  sticky flag: strobe arrived while busy.

Function
REQ-016 FSM states SHALL be IDLE, READ, DRAIN, MIX; on reset the FSM is in IDLE.
REQ-017 In IDLE with pktChanged_i high (cycle T), the block SHALL register pkt_i as dry, delay_i, wetLevel_i and bypass_i, write pkt_i to RAM[wrPtr], increment wrPtr modulo BUF_DEPTH, saturate-increment fillCount at BUF_DEPTH, and go to READ.
REQ-018 READ SHALL last NUM_VOICES cycles (T+1..T+NUM_VOICES) and issue voice v's read address in cycle T+1+v.
REQ-019 Voice v's address SHALL be (address written at T - delay_v) modulo BUF_DEPTH; delay 0 returns the current sample.
REQ-020 The read tap for voice v SHALL contribute 0 when delay_v >= fillCount, because RAM is never cleared.
REQ-021 RAM read latency SHALL be one cycle; taps SHALL accumulate in a signed register PKT_WIDTH+3 bits wide, during READ and in the single DRAIN cycle.
REQ-022 In MIX: wetAvg = accumulator >>> clog2(NUM_VOICES); mixed = (dry*(16-w) + wetAvg*w) >>> 4, signed, arithmetic shift, truncated to PKT_WIDTH. The result always fits, so no saturation.
REQ-023 With bypass captured high, mixed SHALL equal dry, with unchanged timing.
REQ-024 pktMixed_o SHALL update and pktMixChanged_o SHALL pulse for exactly one cycle at T+NUM_VOICES+3; the FSM then returns to IDLE.
REQ-025 A strobe that arrives while busy_o is high SHALL be dropped (no RAM write, no pointer change) and SHALL set overrun_o.
REQ-026 Input changes after cycle T SHALL NOT affect the sample in flight.
REQ-027 The write pointer SHALL wrap from BUF_DEPTH-1 to 0 with no gap.

Reset
REQ-028 Reset SHALL set pktMixed_o, pktMixChanged_o, busy_o, overrun_o, wrPtr, fillCount and the accumulator to 0, and the FSM to IDLE.
REQ-029 Reset during READ, DRAIN or MIX SHALL discard the in-flight sample, and no output strobe SHALL follow.
REQ-030 RAM contents SHALL NOT be reset; REQ-020 masks stale data.

Structure
REQ-031 Package chorus_pkg SHALL hold the FSM state enum, MIX_SHIFT = 4 and WET_FULL = 16.
REQ-032 Delay storage SHALL be sub-module delay_ram: simple dual-port, synchronous write, registered read, one cycle latency, and EBR-inferable.

Verification (bench uses BUF_DEPTH=16, NUM_VOICES=2, so latency is 5)
REQ-033 After reset: pkt 0x1000, delays {0,0}, w=8 -> pktMixed_o=0x1000 with a one-cycle strobe at T+5, and busy_o high T+1..T+4.
REQ-034 First sample after reset: pkt 0x0800, delays {1,1}, w=15 -> wet taps masked to 0; output 0x0080.
REQ-035 Wrap-around: write samples 0..19 (value = index); on sample 19 use delays {3,5}, w=15 -> taps 16 and 14, avg 15; output (19+225)>>4 = 0x000F.
REQ-036 Sign and bypass: pkt 0xC000, delays {0,0}, w=0 -> 0xC000; the same pkt with w=15 and bypass_i=1 -> 0xC000.
REQ-037 Overrun: second strobe at T+2 -> exactly one output strobe (at T+5), overrun_o=1 until reset, and wrPtr advanced by 1.
REQ-038 reset_i asserted at T+2 -> no strobe, all outputs 0, and the next sample is treated as the first (REQ-034 behaviour).
